radix5_preadd_stream: RTL
=========================

# radix5_preadd_stream

Streaming, parametrised first stage of the radix-5 FFT butterfly. It collects five serial complex samples (x0..x4) into a frame, then forms the symmetric pair sums and differences (x1±x4, x2±x3) alongside a width-extended x0. It presents all five results in parallel behind a valid/ready handshake for the twiddle/combine stage. It replaces the fixed 32-bit parallel-input pre-adder with a configurable-width, back-pressured, frame-synchronised version.

## Interface
- DW, 16: input component width, signed two's complement; outputs are DW+1.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage can accept a sample this cycle.
- in_sof  in  1  marks sample x0 of a frame; qualified by in_valid.
- in_re, in_img  in  DW  input sample components.
- out_valid  out  1  result frame valid.
- out_ready  in  1  downstream accepts the frame.
- out_x0_re, out_x0_img  out  DW+1  x0, sign-extended.
- out_s14_re, out_s14_img  out  DW+1  x1+x4.
- out_d14_re, out_d14_img  out  DW+1  x1−x4.
- out_s23_re, out_s23_img  out  DW+1  x2+x3.
- out_d23_re, out_d23_img  out  DW+1  x2−x3.
- sync_err  out  1  one-cycle pulse: partial frame discarded.

## Operation
- Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Sample counter cnt in 0..4. Each input transfer writes the sample into collect slot cnt, then increments cnt, wrapping 4→0.
- Inputs x0..x3 are held in registers. x4 is never stored: on the transfer of x4, the sums and differences are computed from slots 1..3 plus the live x4 and written to the output register. out_valid is set on that same edge.
- in_ready = 1 when cnt≠4. When cnt==4, in_ready = !out_valid || out_ready, so the 5th sample may enter in the same cycle the previous frame drains.
- in_sof on a transfer with cnt≠0: the current partial frame is discarded, sync_err pulses next cycle, and the sample is stored as x0 (cnt→1).
- in_sof on a transfer with cnt==0: normal operation.
- A transfer with cnt==0 and in_sof=0 is accepted as x0. Frames do not require sof.
- Arithmetic: operands are sign-extended to DW+1 before add/sub. Exact, no overflow possible.
- The output register holds its value while out_valid && !out_ready. Outputs must not change until the frame is transferred.

## Timing
- Reset values: cnt=0, out_valid=0, sync_err=0, all data outputs 0, in_ready=1 on the cycle after rst.
- Latency: out_valid rises on the clock edge that accepts x4, and is visible the cycle after that edge.
- Throughput: one sample per cycle sustained with out_ready=1, giving one frame every 5 cycles.
- Simultaneous events:
  - Output drain and x4 arrival in the same cycle: the new frame is loaded and out_valid stays 1.
  - Output drain with no new frame: out_valid→0.
- rst mid-frame or with out_valid=1: the partial frame and the pending output are dropped, with no sync_err.
- in_sof together with cnt==4 and a blocked output: in_ready=0, so the sample is not accepted and nothing changes.

## Configuration
- RADIX5_SAT_EN defined: each sum/difference is saturated to the signed DW range, then sign-extended onto the DW+1 port. Example for DW=16: [−32768, 32767]. This keeps downstream multipliers at DW.
- RADIX5_SAT_EN undefined: full-precision DW+1 results, no saturation logic.
- out_x0 is identical in both modes.

## Structure
- Package radix5_pkg:
  - Localparams for slot indices (X0..X4) and FRAME_LEN=5.
  - Typedef for the counter (3 bits).
  - Function for the saturate-to-DW operation.
- Sub-module radix5_cplx_addsub (parameter DW): one complex pair in, sum and difference out, with optional saturation. It is purely combinational and instantiated twice, for (x1,x4) and (x2,x3).
- Counter, collect registers, output register and handshake live in the top module.

## Test plan
- DW=16, rst then the frame x0..x4 = (1,−1),(100,0),(3,7),(−5,2),(20,−4) with out_ready=1 → one cycle after x4:
  - x0 = (1,−1)
  - s14 = (120,−4), d14 = (80,4)
  - s23 = (−2,9), d23 = (8,5)
  - out_valid for 1 cycle.
- 4 back-to-back frames with in_valid=1 and out_ready=1 → in_ready never drops, and out_valid pulses every 5 cycles with the correct data.
- out_ready=0 while the next frame's x0..x3 arrive → in_ready=0 at cnt==4, outputs stable. out_ready=1 → the new frame loads the same cycle the old one drains.
- in_sof at cnt==2 → sync_err pulses once, and the next output is computed from the new sof sample onward.
- x1 = x4 = (32767,−32768):
  - Without macro: s14 = (65534,−65536).
  - With RADIX5_SAT_EN: s14 = (32767,−32768). d14 = (0,0) in both modes.
- rst asserted with cnt=3 and out_valid=1 → next cycle out_valid=0, cnt=0, sync_err=0, outputs 0.

Source files
------------

// File: rtl/radix5_pkg.sv
// Shared slot indices, counter type and the saturate-to-DW helper for the radix-5 pre-adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package radix5_pkg;
  localparam int X0 = 0;
  localparam int X1 = 1;
  localparam int X2 = 2;
  localparam int X3 = 3;
  localparam int X4 = 4;
  localparam int FRAME_LEN = 5;
  localparam int CNT_W = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/radix5_preadd_stream_if.sv
// Sample-in / frame-out bundle of the radix-5 pre-adder; slave = the stage, master = its environment.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry the valid-ready handshakes.
interface radix5_preadd_stream_if #(parameter int DW = 16);
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_img;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   out_x0_re;
  logic [DW:0]   out_x0_img;
  logic [DW:0]   out_s14_re;
  logic [DW:0]   out_s14_img;
  logic [DW:0]   out_d14_re;
  logic [DW:0]   out_d14_img;
  logic [DW:0]   out_s23_re;
  logic [DW:0]   out_s23_img;
  logic [DW:0]   out_d23_re;
  logic [DW:0]   out_d23_img;
  logic          sync_err;

  modport master (
    output in_valid, in_sof, in_re, in_img, out_ready,
    input  in_ready, out_valid, sync_err,
    input  out_x0_re, out_x0_img, out_s14_re, out_s14_img, out_d14_re, out_d14_img,
    input  out_s23_re, out_s23_img, out_d23_re, out_d23_img
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_img, out_ready,
    output in_ready, out_valid, sync_err,
    output out_x0_re, out_x0_img, out_s14_re, out_s14_img, out_d14_re, out_d14_img,
    output out_s23_re, out_s23_img, out_d23_re, out_d23_img
  );
endinterface

// File: rtl/radix5_cplx_addsub.sv
// Complex a+b and a-b at DW+1 bits; RADIX5_SAT_EN clamps both results to the signed DW range.
// Latency: combinational.
// Backpressure: none (no state).
module radix5_cplx_addsub
  import radix5_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_img,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_img,
  output logic signed [DW:0]   s_re,
  output logic signed [DW:0]   s_img,
  output logic signed [DW:0]   d_re,
  output logic signed [DW:0]   d_img
);
  logic signed [DW:0] s_re_raw, s_img_raw, d_re_raw, d_img_raw;

  // One guard bit makes every sum/difference of two DW-bit operands exact.
  assign s_re_raw  = {a_re[DW-1], a_re} + {b_re[DW-1], b_re};
  assign s_img_raw = {a_img[DW-1], a_img} + {b_img[DW-1], b_img};
  assign d_re_raw  = {a_re[DW-1], a_re} - {b_re[DW-1], b_re};
  assign d_img_raw = {a_img[DW-1], a_img} - {b_img[DW-1], b_img};

`ifdef RADIX5_SAT_EN
  function automatic logic signed [DW:0] sat(input logic signed [DW:0] v);
    return (DW+1)'(sat_to_dw({{(63-DW){v[DW]}}, v}, DW));
  endfunction

  assign s_re  = sat(s_re_raw);
  assign s_img = sat(s_img_raw);
  assign d_re  = sat(d_re_raw);
  assign d_img = sat(d_img_raw);
`else
  assign s_re  = s_re_raw;
  assign s_img = s_img_raw;
  assign d_re  = d_re_raw;
  assign d_img = d_img_raw;
`endif
endmodule

// File: rtl/radix5_preadd_stream.sv
// Collects x0..x4 and presents x0, x1+-x4, x2+-x3 as one frame (RADIX5_SAT_EN saturates sums).
// Latency: frame valid the cycle after x4 is accepted; one frame per 5 cycles sustained.
// Backpressure: in_ready drops only at the x4 slot while an undrained frame is held.
module radix5_preadd_stream
  import radix5_pkg::*;
#(
  parameter int DW = 16
) (
  input logic                   clk,
  input logic                   rst,
  radix5_preadd_stream_if.slave io
);
  logic signed [DW-1:0] slot_re_q [4];
  logic signed [DW-1:0] slot_re_d [4];
  logic signed [DW-1:0] slot_img_q[4];
  logic signed [DW-1:0] slot_img_d[4];
  // Result order: 0=x0, 1=s14, 2=d14, 3=s23, 4=d23.
  logic signed [DW:0]   res_re_q  [5];
  logic signed [DW:0]   res_re_d  [5];
  logic signed [DW:0]   res_img_q [5];
  logic signed [DW:0]   res_img_d [5];
  cnt_t                 cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sync_err_q, sync_err_d;
  logic                 in_rdy, in_xfer;
  logic signed [DW:0]   s14_re, s14_img, d14_re, d14_img;
  logic signed [DW:0]   s23_re, s23_img, d23_re, d23_img;

  // x4 is consumed live from the input bus, never stored.
  radix5_cplx_addsub #(.DW(DW)) u_pair14 (
    .a_re(slot_re_q[X1]), .a_img(slot_img_q[X1]), .b_re(io.in_re), .b_img(io.in_img),
    .s_re(s14_re), .s_img(s14_img), .d_re(d14_re), .d_img(d14_img)
  );

  radix5_cplx_addsub #(.DW(DW)) u_pair23 (
    .a_re(slot_re_q[X2]), .a_img(slot_img_q[X2]), .b_re(slot_re_q[X3]), .b_img(slot_img_q[X3]),
    .s_re(s23_re), .s_img(s23_img), .d_re(d23_re), .d_img(d23_img)
  );

  always_comb begin
    in_rdy      = (cnt_q != cnt_t'(X4)) || !out_valid_q || io.out_ready;
    in_xfer     = io.in_valid && in_rdy;
    cnt_d       = cnt_q;
    slot_re_d   = slot_re_q;
    slot_img_d  = slot_img_q;
    res_re_d    = res_re_q;
    res_img_d   = res_img_q;
    out_valid_d = out_valid_q && !io.out_ready;
    sync_err_d  = 1'b0;
    if (in_xfer) begin
      if (io.in_sof && (cnt_q != cnt_t'(X0))) begin
        sync_err_d        = 1'b1;
        slot_re_d[X0]     = io.in_re;
        slot_img_d[X0]    = io.in_img;
        cnt_d             = cnt_t'(X1);
      end else if (cnt_q == cnt_t'(FRAME_LEN - 1)) begin
        res_re_d[0]  = {slot_re_q[X0][DW-1], slot_re_q[X0]};
        res_img_d[0] = {slot_img_q[X0][DW-1], slot_img_q[X0]};
        res_re_d[1]  = s14_re;
        res_img_d[1] = s14_img;
        res_re_d[2]  = d14_re;
        res_img_d[2] = d14_img;
        res_re_d[3]  = s23_re;
        res_img_d[3] = s23_img;
        res_re_d[4]  = d23_re;
        res_img_d[4] = d23_img;
        out_valid_d  = 1'b1;
        cnt_d        = cnt_t'(X0);
      end else begin
        slot_re_d[cnt_q[1:0]]  = io.in_re;
        slot_img_d[cnt_q[1:0]] = io.in_img;
        cnt_d                  = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= cnt_t'(X0);
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_re_q[i]  <= '0;
        slot_img_q[i] <= '0;
      end
      for (int i = 0; i < 5; i++) begin
        res_re_q[i]  <= '0;
        res_img_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      slot_re_q   <= slot_re_d;
      slot_img_q  <= slot_img_d;
      res_re_q    <= res_re_d;
      res_img_q   <= res_img_d;
    end
  end

  assign io.in_ready    = in_rdy;
  assign io.out_valid   = out_valid_q;
  assign io.sync_err    = sync_err_q;
  assign io.out_x0_re   = res_re_q[0];
  assign io.out_x0_img  = res_img_q[0];
  assign io.out_s14_re  = res_re_q[1];
  assign io.out_s14_img = res_img_q[1];
  assign io.out_d14_re  = res_re_q[2];
  assign io.out_d14_img = res_img_q[2];
  assign io.out_s23_re  = res_re_q[3];
  assign io.out_s23_img = res_img_q[3];
  assign io.out_d23_re  = res_re_q[4];
  assign io.out_d23_img = res_img_q[4];
endmodule
